// File: rtl/mux_n_to_1_scan_if.sv
// rtl/mux_n_to_1_scan_if.sv - channel bus and output handshake for mux_n_to_1_scan
//   A          N*W    packed channel inputs, channel k = A[k*W +: W]
//   control    SEL_W  channel select used in direct mode
//   mode       2      00 direct, 01 scan, 10/11 hold
//   out_ready  1      downstream accepts B this cycle
//   B          W      registered selected channel data
//   sel_out    SEL_W  channel index currently held in B
//   out_valid  1      B holds a valid sample
//   scan_wrap  1      one-cycle pulse after the scan wraps N-1 -> 0
//   master: the side that drives A/control/mode/out_ready; slave: the mux
interface mux_n_to_1_scan_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SEL_W = $clog2(N);

  logic [N*W-1:0]   A;
  logic [SEL_W-1:0] control;
  logic [1:0]       mode;
  logic             out_ready;
  logic [W-1:0]     B;
  logic [SEL_W-1:0] sel_out;
  logic             out_valid;
  logic             scan_wrap;

  modport master (
    output A, control, mode, out_ready,
    input  B, sel_out, out_valid, scan_wrap
  );

  modport slave (
    input  A, control, mode, out_ready,
    output B, sel_out, out_valid, scan_wrap
  );
endinterface

// File: rtl/mux_n_to_1_scan.sv
// rtl/mux_n_to_1_scan.sv - registered N-to-1 mux with direct, round-robin scan and hold modes
//   clk  1      clock, all state changes on the rising edge
//   rst  1      asynchronous active-high reset
//   bus  slave  mux_n_to_1_scan_if: A/control/mode/out_ready in, B/sel_out/out_valid/scan_wrap out
//   N channels of W bits; DWELL cycles per channel in scan mode
module mux_n_to_1_scan #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_n_to_1_scan_if.slave     bus
);

  localparam int SEL_W = $clog2(N);
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_DIRECT = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dwell, dwell_nxt;
  logic [CNT_W-1:0] dwell_base;
  logic [W-1:0]     b_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] sel_adv;
  logic             wrap_nxt;
  logic             stall;

  // A sample that is presented but not taken freezes everything.
  assign stall = bus.out_valid && !bus.out_ready;

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    sel_nxt   = bus.sel_out;
    b_nxt     = bus.B;
    wrap_nxt  = 1'b0;
    // A fresh entry into scan starts counting from zero even if hold
    // left a partial dwell behind.
    dwell_base = (state == ST_SCAN) ? dwell : '0;
    // N is a power of two, so the natural SEL_W-bit overflow is mod N.
    sel_adv    = bus.sel_out + 1'b1;
    if (!stall) begin
      // The presented mode drives this edge's datapath; the state register
      // only remembers it so scan entry can be recognised next time.
      case (bus.mode)
        2'b00: begin
          state_nxt = ST_DIRECT;
          sel_nxt   = bus.control;
          b_nxt     = bus.A[bus.control*W +: W];
          dwell_nxt = '0;
        end
        2'b01: begin
          state_nxt = ST_SCAN;
          if (dwell_base == DWELL_LAST) begin
            dwell_nxt = '0;
            sel_nxt   = sel_adv;
            b_nxt     = bus.A[sel_adv*W +: W];
            wrap_nxt  = (sel_adv == '0);
          end else begin
            dwell_nxt = dwell_base + 1'b1;
            b_nxt     = bus.A[bus.sel_out*W +: W];
          end
        end
        default: begin
          state_nxt = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_DIRECT;
      dwell         <= '0;
      bus.B         <= '0;
      bus.sel_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.scan_wrap <= 1'b0;
    end else begin
      state         <= state_nxt;
      dwell         <= dwell_nxt;
      bus.B         <= b_nxt;
      bus.sel_out   <= sel_nxt;
      bus.out_valid <= 1'b1;
      bus.scan_wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// tb/tb_mux_n_to_1_scan.sv - self-checking bench for mux_n_to_1_scan
module tb_mux_n_to_1_scan;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DWELL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a_arr [4];

  int n_chk  = 0;
  int n_fail = 0;

  mux_n_to_1_scan_if #(.N(N), .W(W)) bus ();

  mux_n_to_1_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.A = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many scan cycles have been spent on the
  // current channel and moves on once DWELL of them have elapsed.
  logic [7:0] m_b;
  int         m_sel;
  logic       m_valid;
  logic       m_wrap;
  bit         m_scanning;
  int         m_spent;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b = 8'h00; m_sel = 0; m_valid = 1'b0; m_wrap = 1'b0;
      m_scanning = 1'b0; m_spent = 0;
    end else begin
      m_wrap = 1'b0;
      if (!(m_valid && !bus.out_ready)) begin
        if (bus.mode == 2'b00) begin
          m_sel = int'(bus.control);
          m_b = a_arr[m_sel];
          m_scanning = 1'b0;
        end else if (bus.mode == 2'b01) begin
          if (!m_scanning) m_spent = 0;
          m_spent++;
          if (m_spent == DWELL) begin
            m_spent = 0;
            m_sel = (m_sel + 1) % N;
            if (m_sel == 0) m_wrap = 1'b1;
          end
          m_b = a_arr[m_sel];
          m_scanning = 1'b1;
        end else begin
          m_scanning = 1'b0;
        end
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_B", 32'(bus.B), 32'(m_b));
      chk("model_sel_out", 32'(bus.sel_out), 32'(m_sel));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model_scan_wrap", 32'(bus.scan_wrap), 32'(m_wrap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int scan_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    a_arr[0] = 8'h11; a_arr[1] = 8'h22; a_arr[2] = 8'h33; a_arr[3] = 8'h44;
    bus.mode = 2'b00; bus.control = 2'd2; bus.out_ready = 1'b1;

    // Reset and direct select
    step(1);
    chk("rst_B", 32'(bus.B), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_scan_wrap", 32'(bus.scan_wrap), 32'h0);
    rst = 1'b0;
    step(1);
    chk("direct_B", 32'(bus.B), 32'h33);
    chk("direct_sel", 32'(bus.sel_out), 32'd2);
    chk("direct_valid", 32'(bus.out_valid), 32'd1);

    // Full scan with wrap
    bus.control = 2'd0;
    step(1);
    chk("scan_pre_sel", 32'(bus.sel_out), 32'(scan_seq[0]));
    bus.mode = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("scan_seq_sel", 32'(bus.sel_out), 32'(scan_seq[i]));
      chk("scan_seq_wrap", 32'(bus.scan_wrap), (i == 12) ? 32'd1 : 32'd0);
    end

    // Stall on channel 1 at dwell count 1
    step(4);
    chk("stall_pre_sel", 32'(bus.sel_out), 32'd1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_B", 32'(bus.B), 32'h22);
      chk("stall_sel", 32'(bus.sel_out), 32'd1);
    end
    bus.out_ready = 1'b1;
    step(1);
    chk("unstall_sel_a", 32'(bus.sel_out), 32'd1);
    step(1);
    chk("unstall_sel_b", 32'(bus.sel_out), 32'd2);
    chk("unstall_B", 32'(bus.B), 32'h33);

    // Hold ignores input changes
    bus.mode = 2'b10;
    step(1);
    a_arr[2] = 8'hAA;
    step(3);
    chk("hold_B", 32'(bus.B), 32'h33);
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    bus.mode = 2'b00; bus.control = 2'd2;
    step(1);
    chk("hold_exit_B", 32'(bus.B), 32'hAA);
    a_arr[2] = 8'h33;
    step(1);

    // Mode 11 behaves as hold, then a fresh scan entry restarts the dwell
    bus.mode = 2'b01;
    step(1);
    bus.mode = 2'b11;
    step(3);
    chk("mode11_sel", 32'(bus.sel_out), 32'd2);
    chk("mode11_B", 32'(bus.B), 32'h33);
    bus.mode = 2'b01;
    step(2);
    chk("reentry_sel_a", 32'(bus.sel_out), 32'd2);
    step(1);
    chk("reentry_sel_b", 32'(bus.sel_out), 32'd3);

    // Terminal count collides with a switch to direct
    step(2);
    bus.mode = 2'b00; bus.control = 2'd0;
    step(1);
    chk("collide_sel", 32'(bus.sel_out), 32'd0);
    chk("collide_wrap", 32'(bus.scan_wrap), 32'd0);
    chk("collide_B", 32'(bus.B), 32'h11);

    // Asynchronous reset between edges while on channel 3
    bus.mode = 2'b01;
    step(9);
    chk("prereset_sel", 32'(bus.sel_out), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_B", 32'(bus.B), 32'h0);
    chk("async_sel", 32'(bus.sel_out), 32'd0);
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_wrap", 32'(bus.scan_wrap), 32'd0);
    #1;
    rst = 1'b0;
    step(2);
    chk("restart_sel_a", 32'(bus.sel_out), 32'd0);
    step(1);
    chk("restart_sel_b", 32'(bus.sel_out), 32'd1);
    chk("restart_B", 32'(bus.B), 32'h22);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
